// File: rtl/rsp_skid_fifo_pkg.sv
// Shared constants for the memory-response elastic buffer.
// DATA_WIDTH is the core payload width; RSP_FIFO_DEPTH is the default
// buffer depth; ptr_w() gives the pointer width for a given depth.
package rsp_skid_fifo_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int RSP_FIFO_DEPTH = 4;

  // Pointer width for a power-of-two depth (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rsp_skid_fifo_ram.sv
// DEPTH x DW flop storage for the response FIFO.
// It has one synchronous write port and one asynchronous read port.
// The storage is deliberately not reset, because the pointers and level
// alone decide which entries are valid.
module rsp_skid_fifo_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write the accepted beat into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rsp_skid_fifo.sv
// Elastic buffer between the memory response channel and the core/LSU.
// It applies valid/ready backpressure on both sides and holds a DEPTH-entry store.
// It also reports its fill level and an almost-full flag, and it accepts a synchronous flush.
// Every output decodes from registered state, so there is no combinational
// path from one side of the buffer to the other.
// Optional feature, enabled with macro RSP_SKID_FIFO_STATS_EN:
//   - hwm: high-water mark of level.
//   - ovf_attempt: sticky flag that is set by a push offered while the buffer is full.
module rsp_skid_fifo
  import rsp_skid_fifo_pkg::*;
#(
  parameter int DW       = DATA_WIDTH,
  parameter int DEPTH    = RSP_FIFO_DEPTH,
  parameter int AFULL_TH = DEPTH - 1,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          m_rsp_vld,
  output logic          m_rsp_rdy,
  input  logic [DW-1:0] m_rsp_data,
  output logic          src_vld,
  input  logic          src_rdy,
  output logic [DW-1:0] src_data,
  output logic [LW-1:0] level,
`ifdef RSP_SKID_FIFO_STATS_EN
  output logic [LW-1:0] hwm,
  output logic          ovf_attempt,
`endif
  output logic          afull
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [LW-1:0] FULL_LV  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LV = LW'(AFULL_TH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [DW-1:0] head_data;
  logic          rst_done;
  logic          push, pop;

  // Ready is held low until the first edge after reset is released.
  assign m_rsp_rdy = rst_done & (level != FULL_LV);
  assign src_vld   = (level != '0);
  assign afull     = (level >= AFULL_LV);
  assign src_data  = src_vld ? head_data : '0;

  assign push = m_rsp_vld & m_rsp_rdy;
  assign pop  = src_vld & src_rdy;

  // Flush discards everything, including a beat that is offered in the same cycle.
  always_comb begin
    level_nxt = level + LW'(push) - LW'(pop);
    if (flush) level_nxt = '0;
  end

  // Pointers, level and the out-of-reset flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      level    <= level_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  rsp_skid_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (m_rsp_data),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

`ifdef RSP_SKID_FIFO_STATS_EN
  // The high-water mark and the overflow-attempt flag are cleared only by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm         <= '0;
      ovf_attempt <= 1'b0;
    end else if (flush) begin
      hwm         <= '0;
      ovf_attempt <= 1'b0;
    end else begin
      if (level_nxt > hwm) hwm <= level_nxt;
      if (m_rsp_vld && !m_rsp_rdy) ovf_attempt <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rsp_skid_fifo.sv
// Directed testbench for rsp_skid_fifo with DW=32, DEPTH=4 and AFULL_TH=3.
// Inputs are driven 1 time unit after the rising edge, and outputs are checked at that same point.
module tb_rsp_skid_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        m_rsp_vld;
  logic        m_rsp_rdy;
  logic [31:0] m_rsp_data;
  logic        src_vld;
  logic        src_rdy;
  logic [31:0] src_data;
  logic [2:0]  level;
  logic        afull;
`ifdef RSP_SKID_FIFO_STATS_EN
  logic [2:0]  hwm;
  logic        ovf_attempt;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rsp_skid_fifo #(.DW(32), .DEPTH(4), .AFULL_TH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .m_rsp_vld   (m_rsp_vld),
    .m_rsp_rdy   (m_rsp_rdy),
    .m_rsp_data  (m_rsp_data),
    .src_vld     (src_vld),
    .src_rdy     (src_rdy),
    .src_data    (src_data),
    .level       (level),
`ifdef RSP_SKID_FIFO_STATS_EN
    .hwm         (hwm),
    .ovf_attempt (ovf_attempt),
`endif
    .afull       (afull)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; m_rsp_vld = 1'b0; m_rsp_data = '0; src_rdy = 1'b0;
    step(); step();
    compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", level); end
    compared++; if (src_vld !== 1'b0) begin mismatched++; $display("FAIL reset_src_vld got %b want 0", src_vld); end
    compared++; if (m_rsp_rdy !== 1'b0) begin mismatched++; $display("FAIL reset_rdy got %b want 0", m_rsp_rdy); end
    compared++; if (afull !== 1'b0) begin mismatched++; $display("FAIL reset_afull got %b want 0", afull); end
    compared++; if (src_data !== 32'h0) begin mismatched++; $display("FAIL reset_src_data got %h want 0", src_data); end
    rst_n = 1'b1;
    step();
    compared++; if (m_rsp_rdy !== 1'b1) begin mismatched++; $display("FAIL post_reset_rdy got %b want 1", m_rsp_rdy); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      m_rsp_vld = 1'b1; m_rsp_data = 32'hA0 + i;
      step();
      compared++; if (level !== 3'(i + 1)) begin mismatched++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, i + 1); end
      compared++; if (afull !== ((i + 1) >= 3)) begin mismatched++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull, (i + 1) >= 3); end
      compared++; if (m_rsp_rdy !== ((i + 1) < 4)) begin mismatched++; $display("FAIL fill_rdy[%0d] got %b want %b", i, m_rsp_rdy, (i + 1) < 4); end
      compared++; if (src_data !== 32'hA0) begin mismatched++; $display("FAIL fill_head[%0d] got %h want a0", i, src_data); end
    end
    m_rsp_vld = 1'b0; src_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++; if (src_data !== 32'hA0 + i) begin mismatched++; $display("FAIL drain_data[%0d] got %h want %h", i, src_data, 32'hA0 + i); end
      step();
      compared++; if (level !== 3'(3 - i)) begin mismatched++; $display("FAIL drain_level[%0d] got %0d want %0d", i, level, 3 - i); end
    end
    compared++; if (src_vld !== 1'b0) begin mismatched++; $display("FAIL drain_empty_vld got %b want 0", src_vld); end
    src_rdy = 1'b0;
  endtask

  task automatic test_streaming();
    int nout = 0;
    src_rdy = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      m_rsp_vld = (c < 16); m_rsp_data = c;
      if (src_vld) begin
        compared++; if (src_data !== 32'(nout)) begin mismatched++; $display("FAIL stream_data[%0d] got %h want %h", nout, src_data, nout); end
        nout++;
      end
      step();
      compared++; if (level !== ((c < 16) ? 3'd1 : 3'd0)) begin mismatched++; $display("FAIL stream_level[%0d] got %0d want %0d", c, level, (c < 16) ? 1 : 0); end
    end
    compared++; if (nout !== 16) begin mismatched++; $display("FAIL stream_count got %0d want 16", nout); end
    m_rsp_vld = 1'b0; src_rdy = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'hB1; exp_q[1] = 32'hB2; exp_q[2] = 32'hB3; exp_q[3] = 32'hBB;
    for (int i = 0; i < 4; i++) begin
      m_rsp_vld = 1'b1; m_rsp_data = 32'hB0 + i;
      step();
    end
    compared++; if (m_rsp_rdy !== 1'b0) begin mismatched++; $display("FAIL full_rdy got %b want 0", m_rsp_rdy); end
    m_rsp_data = 32'hBB; src_rdy = 1'b1;
    step();
    compared++; if (level !== 3'd3) begin mismatched++; $display("FAIL full_pop_level got %0d want 3", level); end
    compared++; if (m_rsp_rdy !== 1'b1) begin mismatched++; $display("FAIL full_freed_rdy got %b want 1", m_rsp_rdy); end
    src_rdy = 1'b0;
    step();
    compared++; if (level !== 3'd4) begin mismatched++; $display("FAIL full_refill_level got %0d want 4", level); end
    m_rsp_vld = 1'b0; src_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++; if (src_data !== exp_q[i]) begin mismatched++; $display("FAIL full_drain[%0d] got %h want %h", i, src_data, exp_q[i]); end
      step();
    end
    compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL full_final_level got %0d want 0", level); end
    src_rdy = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      m_rsp_vld = 1'b1; m_rsp_data = 32'hC0 + i;
      step();
    end
    compared++; if (afull !== 1'b1) begin mismatched++; $display("FAIL flush_pre_afull got %b want 1", afull); end
    m_rsp_data = 32'hCC; flush = 1'b1;
    step();
    flush = 1'b0; m_rsp_vld = 1'b0;
    compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL flush_level got %0d want 0", level); end
    compared++; if (src_vld !== 1'b0) begin mismatched++; $display("FAIL flush_src_vld got %b want 0", src_vld); end
    compared++; if (src_data !== 32'h0) begin mismatched++; $display("FAIL flush_src_data got %h want 0", src_data); end
    m_rsp_vld = 1'b1; m_rsp_data = 32'hD0;
    step();
    m_rsp_vld = 1'b0;
    compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL flush_after_level got %0d want 1", level); end
    compared++; if (src_data !== 32'hD0) begin mismatched++; $display("FAIL flush_after_data got %h want d0", src_data); end
    src_rdy = 1'b1;
    step();
    src_rdy = 1'b0;
    compared++; if (src_vld !== 1'b0) begin mismatched++; $display("FAIL flush_after_empty got %b want 0", src_vld); end
  endtask

  task automatic test_async_reset();
    m_rsp_vld = 1'b1; m_rsp_data = 32'h10; step();
    m_rsp_data = 32'h20; step();
    compared++; if (level !== 3'd2) begin mismatched++; $display("FAIL arst_pre_level got %0d want 2", level); end
    m_rsp_data = 32'h30;
    #2 rst_n = 1'b0;
    #1;
    compared++; if (src_vld !== 1'b0) begin mismatched++; $display("FAIL arst_src_vld got %b want 0", src_vld); end
    compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL arst_level got %0d want 0", level); end
    compared++; if (afull !== 1'b0) begin mismatched++; $display("FAIL arst_afull got %b want 0", afull); end
    m_rsp_vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_rsp_vld = 1'b1; m_rsp_data = 32'h11;
    step();
    m_rsp_vld = 1'b0;
    compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL arst_after_level got %0d want 1", level); end
    compared++; if (src_data !== 32'h11) begin mismatched++; $display("FAIL arst_after_data got %h want 11", src_data); end
    src_rdy = 1'b1;
    step();
    src_rdy = 1'b0;
    compared++; if (src_vld !== 1'b0) begin mismatched++; $display("FAIL arst_after_empty got %b want 0", src_vld); end
  endtask

`ifdef RSP_SKID_FIFO_STATS_EN
  task automatic test_stats();
    flush = 1'b1; step(); flush = 1'b0;
    compared++; if (hwm !== 3'd0) begin mismatched++; $display("FAIL stats_clr_hwm got %0d want 0", hwm); end
    compared++; if (ovf_attempt !== 1'b0) begin mismatched++; $display("FAIL stats_clr_ovf got %b want 0", ovf_attempt); end
    for (int i = 0; i < 4; i++) begin
      m_rsp_vld = 1'b1; m_rsp_data = 32'hE0 + i;
      step();
    end
    compared++; if (ovf_attempt !== 1'b0) begin mismatched++; $display("FAIL stats_no_ovf got %b want 0", ovf_attempt); end
    m_rsp_data = 32'hEE;
    step(); step();
    m_rsp_vld = 1'b0;
    compared++; if (hwm !== 3'd4) begin mismatched++; $display("FAIL stats_hwm got %0d want 4", hwm); end
    compared++; if (ovf_attempt !== 1'b1) begin mismatched++; $display("FAIL stats_ovf got %b want 1", ovf_attempt); end
    flush = 1'b1; step(); flush = 1'b0;
    compared++; if (hwm !== 3'd0) begin mismatched++; $display("FAIL stats_flush_hwm got %0d want 0", hwm); end
    compared++; if (ovf_attempt !== 1'b0) begin mismatched++; $display("FAIL stats_flush_ovf got %b want 0", ovf_attempt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_simul();
    test_flush();
    test_async_reset();
`ifdef RSP_SKID_FIFO_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
